// File: rtl/sync_singleport_ram.sv
// ---------------------------------------------------------------------------
// sync_singleport_ram
//
// Clocked single-port RAM with a shared bidirectional data bus. After reset,
// a sequencer zeroes every word (busy=1). Once that finishes, it accepts one
// access per clock. Reads are pipelined with a latency of 1 or 2 clocks.
// Rejected accesses raise err for one cycle. An access is rejected when it
// collides (we and re together), arrives while busy, or is out of range.
//
// Ports:
//   clk      : clock, all state changes on the rising edge
//   rst      : synchronous active-high reset, restarts the clear sequence
//   we       : write strobe, writes the data bus value to mem[addr]
//   re       : read strobe, returns mem[addr] READ_LATENCY clocks later
//   addr     : word address
//   data     : shared bus, driven by the host for writes and by this block
//              only while rd_valid is high
//   busy     : high while the auto-clear sequence runs
//   rd_valid : high exactly in the cycles this block drives data
//   err      : one-cycle pulse after a rejected access
//
// Parameters: WIDTH, DEPTH (any value <= 2**ADDR_WIDTH), ADDR_WIDTH,
// READ_LATENCY (1 or 2).
// ---------------------------------------------------------------------------
module sync_singleport_ram #(
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned ADDR_WIDTH   = 3,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    inout  wire  [WIDTH-1:0]      data,
    output logic                  busy,
    output logic                  rd_valid,
    output logic                  err
);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_IDLE  = 1'b1;

    // DEPTH widened by one bit so that a full power-of-two depth still fits
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR  = ADDR_WIDTH'(DEPTH - 1);

    logic [WIDTH-1:0]      mem_q [DEPTH];

    logic [0:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic                  err_q, err_d;

    logic                  in_range;
    logic                  wr_ok;
    logic                  rd_ok;

    logic                  rd_v1_q;
    logic [WIDTH-1:0]      rd_w1_q;

    logic                  out_v;
    logic [WIDTH-1:0]      out_w;

    assign busy = (state_q == ST_CLEAR);

    // Access decode and clear sequencer next state
    always_comb begin
        in_range = ({1'b0, addr} < DEPTH_EXT);
        wr_ok    = !busy && we && !re && in_range;
        rd_ok    = !busy && re && !we && in_range;
        // Any strobe that is not a clean read or write is a violation
        err_d    = (we || re) && !(wr_ok || rd_ok);

        state_d  = state_q;
        ptr_d    = ptr_q;
        if (state_q == ST_CLEAR) begin
            ptr_d = ptr_q + 1'b1;
            if (ptr_q == LAST_PTR) begin
                state_d = ST_IDLE;
                ptr_d   = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
            err_q   <= 1'b0;
            rd_v1_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
            rd_v1_q <= rd_ok;
        end
    end

    // Storage has no reset; the clear sequence zeroes it word by word
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (busy) begin
                mem_q[ptr_q] <= '0;
            end else if (wr_ok) begin
                mem_q[addr] <= data;
            end
        end
    end

    // First read stage: the word is captured at the request edge, so a
    // later write to the same address cannot change a read already issued
    always_ff @(posedge clk) begin
        if (rd_ok) begin
            rd_w1_q <= mem_q[addr];
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic             rd_v2_q;
        logic [WIDTH-1:0] rd_w2_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                rd_v2_q <= 1'b0;
            end else begin
                rd_v2_q <= rd_v1_q;
            end
        end

        always_ff @(posedge clk) begin
            if (rd_v1_q) begin
                rd_w2_q <= rd_w1_q;
            end
        end

        assign out_v = rd_v2_q;
        assign out_w = rd_w2_q;
    end else begin : g_lat1
        assign out_v = rd_v1_q;
        assign out_w = rd_w1_q;
    end

    assign rd_valid = out_v;
    assign err      = err_q;
    assign data     = out_v ? out_w : 'z;

endmodule

// File: doc/sync_singleport_ram.md
Name: sync_singleport_ram

Overview:
Parametrised, synchronous single-port RAM with a shared bidirectional data bus and we/re strobes. It is the clocked successor of the 8x16 asynchronous single-port memory, with generic width and depth, selectable read latency, and a post-reset auto-clear sequencer. Access-violation flagging covers collisions, busy and out-of-range cases. It sits behind simple host/bus masters as scratch storage.

Parameters:
WIDTH, 16, data word width in bits
DEPTH, 8, number of words (need not be a power of two)
ADDR_WIDTH, 3, address width; must satisfy 2^ADDR_WIDTH >= DEPTH
READ_LATENCY, 1, read latency in clocks from the sampling edge to data on the bus; legal values are 1 and 2

Ports:
clk  input  1  clock; all state changes on the rising edge
rst  input  1  synchronous, active-high reset
we  input  1  write strobe
re  input  1  read strobe
addr  input  ADDR_WIDTH  word address
data  inout  WIDTH  shared data bus; host drives it for writes, block drives it for reads
busy  output  1  high while the auto-clear sequence runs
rd_valid  output  1  high for exactly the cycles in which the block drives data
err  output  1  one-cycle pulse on a rejected access

Behaviour:
- Reset: one clock is synchronous and active-high, named clk and rst.
  - rst=1 at an edge sets state to CLEAR, clear pointer to 0, busy=1, rd_valid=0, err=0.
  - Any in-flight read pipeline stages are flushed; data is released (Z).
  - Memory contents are not reset directly; they are zeroed by the CLEAR state.
- FSM states: CLEAR, IDLE.
  - CLEAR: each edge writes 0 to mem[ptr] and increments ptr. The write of DEPTH-1 moves the FSM to IDLE.
  - busy is high for exactly DEPTH cycles after rst deasserts, then falls.
  - IDLE: normal operation; stays in IDLE until rst.
  - rst asserted mid-CLEAR restarts the clear from address 0.
- Access is decoded at each rising edge in IDLE:
  - we=1, re=0, addr<DEPTH: mem[addr] <= data (bus value sampled at the edge).
  - re=1, we=0, addr<DEPTH: read issued.
    - READ_LATENCY=1: mem[addr] is registered at edge N. rd_valid=1 and data=that word during the cycle after edge N.
    - READ_LATENCY=2: one extra output register stage; data is valid during the cycle after edge N+1.
  - we=1, re=1: no memory change, no read; err=1 for the next cycle.
  - (we or re)=1 with addr>=DEPTH: ignored; err=1 for the next cycle.
  - (we or re)=1 while busy: ignored; err=1 for the next cycle.
  - we=0, re=0: no operation.
- Bus driver:
  - data = read word when rd_valid=1, else Z.
  - The host must not drive data during rd_valid cycles; the block never drives data otherwise.
- Back-to-back reads are fully pipelined: one result per cycle, with rd_valid held high continuously.
- Read-after-write: a write at edge N followed by a read of the same address at edge N+1 returns the new data.
- A write issued while an earlier read is still in the pipeline does not alter that read's returned value.
  - The host is responsible for not driving data during rd_valid; bus contention is a host protocol violation.
- err depends only on the inputs sampled at the previous edge; it is never sticky.

Test Plan:
1. Reset/clear: assert rst for 2 cycles, then release (WIDTH=16, DEPTH=8).
   -> busy=1 for exactly 8 cycles, then 0.
   -> Reading addresses 0..7 then returns 16'h0000 each, with rd_valid high one cycle per read and data=Z otherwise.
2. Write/read sweep (LATENCY=1): write addr i with random words for i=0..7, then read 0..7 back to back.
   -> rd_valid stays high for 8 consecutive cycles.
   -> data equals the written words, in order, each one cycle after its request.
3. LATENCY=2 build: write 16'hA5A5 to addr 3, then read addr 3.
   -> data=16'hA5A5 with rd_valid=1 exactly two cycles after the read edge.
4. Violations, each giving a single-cycle err pulse with memory unchanged (checked by read-back):
   - we=re=1 at addr 2;
   - read of addr 3 while busy;
   - DEPTH=6 build, write to addr 7.
5. Read-after-write: write 16'h1234 to addr 5, then on the next edge read addr 5.
   -> returns 16'h1234.
6. Reset mid-operation: assert rst during an issued read, and again during CLEAR at ptr=4.
   -> rd_valid=0, data=Z the cycle after reset.
   -> Clear restarts at addr 0, and busy lasts a full DEPTH cycles after rst release.
